iiitb_gc_decoder: RTL and testbench

Receive-side counterpart of the gray_count generator. It samples an incoming WIDTH-bit Gray code and converts it to binary. It also checks that successive values only hold or advance by +1 modulo 2^WIDTH, and reports lock, step errors and a saturating error count. It sits on the consumer side of the gray counter bus, for use in self-checking and clock-crossing count transfer.

---
 rtl/iiitb_gc_decoder.sv | 162 ++++++++++++++++
 tb/tb_iiitb_gc_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_gc_decoder.sv
// Gray-code receiver: decodes gray_in to binary and checks +1/hold stepping.
// Define IIITB_GC_DEC_SYNC_EN to add a 2-flop input synchronizer.
module iiitb_gc_decoder #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             locked,
  output logic             step_err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] g_d, g_q;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       good_q, good_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             step_err_q, step_err_d;
  logic [7:0]       err_q, err_d;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] delta;
  logic             acc;

`ifdef IIITB_GC_DEC_SYNC_EN
  logic [WIDTH-1:0] s1_q, s2_q;

  // Two-flop synchronizer ahead of the sample register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= gray_in;
      s2_q <= s1_q;
    end
  end

  assign g_d = s2_q;
`else
  assign g_d = gray_in;
`endif

  // Sample register, free-running regardless of enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) g_q <= '0;
    else        g_q <= g_d;
  end

  // Gray to binary: running XOR from the MSB down
  always_comb begin
    b   = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g_q[i];
      b[i] = acc;
    end
  end

  assign delta = b - prev_q;

  // Checker state machine: next state and registered outputs
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    prev_d     = prev_q;
    good_d     = good_q;
    valid_d    = valid_q;
    locked_d   = locked_q;
    step_err_d = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        valid_d  = 1'b0;
        locked_d = 1'b0;
        if (enable) begin
          bin_d   = b;
          prev_d  = b;
          valid_d = 1'b1;
          good_d  = '0;
          state_d = ACQ;
        end
      end
      ACQ, LOCKED: begin
        if (!enable) begin
          valid_d  = 1'b0;
          locked_d = 1'b0;
          state_d  = IDLE;
        end else begin
          bin_d  = b;
          prev_d = b;
          if (delta == ONE) begin
            if (state_q == ACQ) begin
              good_d = good_q + 4'd1;
              if (good_d == LOCK_N) begin
                locked_d = 1'b1;
                state_d  = LOCKED;
              end
            end
          end else if (delta != '0) begin
            step_err_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            good_d   = '0;
            locked_d = 1'b0;
            state_d  = ACQ;
          end
        end
      end
      default: begin
        valid_d  = 1'b0;
        locked_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Checker state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      prev_q     <= '0;
      good_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      step_err_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      step_err_q <= step_err_d;
      err_q      <= err_d;
    end
  end

  assign bin_out   = bin_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign step_err  = step_err_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_iiitb_gc_decoder.sv
// Bench for iiitb_gc_decoder: scoreboard against a sample-level model.
// Build with IIITB_GC_DEC_SYNC_EN to exercise the synchronized variant.
module tb_iiitb_gc_decoder;

  localparam int W  = 8;
  localparam int LK = 4;
`ifdef IIITB_GC_DEC_SYNC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] gray_in;
  logic [W-1:0] bin_out;
  logic         valid;
  logic         locked;
  logic         step_err;
  logic [7:0]   err_count;

  iiitb_gc_decoder #(.WIDTH(W), .LOCK_CNT(LK)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .valid     (valid),
    .locked    (locked),
    .step_err  (step_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bin;
    logic       v;
    logic       l;
    logic       s;
    logic [7:0] e;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] pipe[DEPTH];
  bit         m_act, m_lock, m_step;
  int         m_good, m_err;
  logic [7:0] m_prev, m_bin;

  function automatic logic [7:0] gray(input int n);
    logic [7:0] v;
    v = 8'(n);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) pipe[i] = '0;
    m_act  = 0;
    m_lock = 0;
    m_step = 0;
    m_good = 0;
    m_err  = 0;
    m_prev = '0;
    m_bin  = '0;
  endtask

  // Model of one clock edge in terms of decoded samples
  task automatic model_step(input logic r, input logic e,
                            input logic [7:0] g);
    logic [7:0] b, d;
    exp_t x;
    if (!r) begin
      model_reset();
    end else begin
      b      = g2b(pipe[DEPTH-1]);
      m_step = 0;
      if (!m_act) begin
        if (e) begin
          m_bin  = b;
          m_prev = b;
          m_act  = 1;
          m_good = 0;
        end
      end else if (!e) begin
        m_act  = 0;
        m_lock = 0;
      end else begin
        d      = b - m_prev;
        m_bin  = b;
        m_prev = b;
        if (d == 8'd1) begin
          if (!m_lock) begin
            m_good++;
            if (m_good == LK) m_lock = 1;
          end
        end else if (d != 8'd0) begin
          m_step = 1;
          if (m_err < 255) m_err++;
          m_good = 0;
          m_lock = 0;
        end
      end
      for (int i = DEPTH - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = g;
    end
    x.bin = m_bin;
    x.v   = m_act;
    x.l   = m_lock;
    x.s   = m_step;
    x.e   = 8'(m_err);
    q.push_back(x);
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [7:0] g);
    @(negedge clk);
    reset   = r;
    enable  = e;
    gray_in = g;
    model_step(r, e, g);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bin"},   bin_out,   8'h00);
    chk({tag, "_valid"}, {7'd0, valid},    8'h00);
    chk({tag, "_lock"},  {7'd0, locked},   8'h00);
    chk({tag, "_serr"},  {7'd0, step_err}, 8'h00);
    chk({tag, "_ecnt"},  err_count, 8'h00);
  endtask

  // Monitor: one expected bundle per edge, compared after it settles
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("bin_out",   x.v ? bin_out : x.bin, x.bin);
      chk("valid",     {7'd0, valid},    {7'd0, x.v});
      chk("locked",    {7'd0, locked},   {7'd0, x.l});
      chk("step_err",  {7'd0, step_err}, {7'd0, x.s});
      chk("err_count", err_count, x.e);
    end
  end

  initial begin
    int cur, p;
    logic r, e;
    reset   = 1'b0;
    enable  = 1'b0;
    gray_in = '0;
    model_reset();
    #3;
    chk_zero("reset");

    for (int i = 0; i <= 20; i++) step(1, 1, gray(i));
    for (int i = 244; i <= 255; i++) step(1, 1, gray(i));
    for (int i = 0; i <= 5; i++) step(1, 1, gray(i));
    for (int i = 6; i <= 10; i++) step(1, 1, gray(i));
    for (int i = 12; i <= 17; i++) step(1, 1, gray(i));
    for (int i = 0; i <= 7; i++) step(1, 1, gray(i));
    for (int i = 0; i < 10; i++) step(1, 1, gray(7));
    for (int i = 0; i < 3; i++) step(1, 0, gray(7));
    for (int i = 0; i < 300; i++)
      step(1, 1, (i % 2) ? gray(5) : gray(0));

    step(0, 1, gray(3));
    #2;
    chk_zero("areset");
    step(0, 1, gray(4));
    for (int i = 0; i <= 20; i++) step(1, 1, gray(i));

    cur = 0;
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 19) != 0);
      p = $urandom_range(0, 99);
      if (p < 70)      cur = (cur + 1) % 256;
      else if (p < 85) cur = cur;
      else             cur = $urandom_range(0, 255);
      step(r, e, gray(cur));
    end

    step(1, 1, gray(cur));
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
